// File: rtl/hc595_ctrl.sv
// Serialises a {seg, sel} frame into a 74HC595 chain: LOAD -> SHIFT -> LATCH, refreshing continuously.
// Frame takes 1 + 15*CLK_DIV cycles. All pins are registered and the inputs are snapshotted in LOAD.
module hc595_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       frame_done
);

    localparam int            PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
    localparam logic [3:0]    BIT_LAST = 4'd13;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    bit_q, bit_d;
    logic [13:0]   frame_q, frame_d, frame_in;
    logic          ds_q, ds_d;
    logic          shcp_q, shcp_d;
    logic          stcp_q, stcp_d;
    logic          oe_q, oe_d;
    logic          done_q, done_d;

    // Shift order: sel[0] first, then the segment code MSB (dp) down to seg[0].
    assign frame_in = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6], seg[7], sel};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= LOAD;
            phase_q <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        case (state_q)
            LOAD: begin
                frame_d = frame_in;
                phase_d = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LATCH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = LOAD;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
                phase_d = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Pin values are computed from the next state so each register lines up with the state it describes.
    always_comb begin
        shcp_d = (state_d == SHIFT) && (phase_d >= PH_HALF);
        stcp_d = (state_d == LATCH);
        done_d = (state_d == LATCH) && (phase_d == PH_LAST);
        ds_d   = ds_q;
        if ((state_d == SHIFT) && (phase_d == '0)) begin
            ds_d = frame_d[bit_d];
        end
        oe_d = done_q ? 1'b0 : oe_q;
    end

    assign ds         = ds_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign oe         = oe_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Drives two controllers (CLK_DIV 4 and 8) from shared inputs and watches their pins with a 74HC595 pin-level model.
module tb_hc595_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [5:0] sel;
    logic [7:0] seg;
    logic [1:0] ds_v, shcp_v, stcp_v, oe_v, fd_v;

    int checks = 0;
    int errors = 0;

    hc595_ctrl #(.CLK_DIV(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sel(sel), .seg(seg),
        .ds(ds_v[0]), .shcp(shcp_v[0]), .stcp(stcp_v[0]), .oe(oe_v[0]), .frame_done(fd_v[0])
    );

    hc595_ctrl #(.CLK_DIV(8)) dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sel(sel), .seg(seg),
        .ds(ds_v[1]), .shcp(shcp_v[1]), .stcp(stcp_v[1]), .oe(oe_v[1]), .frame_done(fd_v[1])
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] exp_bits(input logic [5:0] s, input logic [7:0] g);
        logic [13:0] w;
        for (int i = 0; i < 14; i++) w[i] = (i < 6) ? s[i] : g[13 - i];
        return w;
    endfunction

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    int          cyc = 0;
    logic        prev_shcp[2], prev_stcp[2], prev_ds[2];
    logic [13:0] shbuf[2], latched[2], exp_latch[2];
    logic [13:0] snap0[$], snap1[$];
    int rises[2], rises_at_latch[2], ds_age[2], last_rise[2], period[2];
    int hi_run[2], hi_len[2], stcp_run[2], stcp_len[2];
    int fd_cnt[2], fd_cyc[2], fd_gap[2], first_oe_low[2];
    int overlap[2] = '{0, 0};
    int setup_viol[2] = '{0, 0};
    int ds_hi_change[2] = '{0, 0};
    int oe_relapse[2] = '{0, 0};

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            cyc = 0;
            snap0.delete();
            snap1.delete();
            for (int d = 0; d < 2; d++) begin
                prev_shcp[d] = 1'b0; prev_stcp[d] = 1'b0; prev_ds[d] = 1'b0;
                shbuf[d] = '0; rises[d] = 0; ds_age[d] = 0; last_rise[d] = -1;
                hi_run[d] = 0; stcp_run[d] = 0;
                fd_cnt[d] = 0; fd_cyc[d] = -1; first_oe_low[d] = -1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (cyc % (1 + 15 * div_of(d)) == 0) begin
                    if (d == 0) snap0.push_back(exp_bits(sel, seg));
                    else        snap1.push_back(exp_bits(sel, seg));
                end
                if (ds_v[d] !== prev_ds[d]) begin
                    ds_age[d] = 0;
                    if (shcp_v[d]) ds_hi_change[d]++;
                end else begin
                    ds_age[d]++;
                end
                if (shcp_v[d] && !prev_shcp[d]) begin
                    if (rises[d] < 14) shbuf[d][rises[d]] = ds_v[d];
                    rises[d]++;
                    if (ds_age[d] < div_of(d) / 2) setup_viol[d]++;
                    if (last_rise[d] >= 0) period[d] = cyc - last_rise[d];
                    last_rise[d] = cyc;
                end
                if (shcp_v[d]) hi_run[d]++;
                else if (prev_shcp[d]) begin hi_len[d] = hi_run[d]; hi_run[d] = 0; end
                if (stcp_v[d] && !prev_stcp[d]) begin
                    latched[d] = shbuf[d];
                    rises_at_latch[d] = rises[d];
                    rises[d] = 0;
                    shbuf[d] = '0;
                    last_rise[d] = -1;
                    if (d == 0) exp_latch[d] = (snap0.size() > 0) ? snap0.pop_front() : 14'bx;
                    else        exp_latch[d] = (snap1.size() > 0) ? snap1.pop_front() : 14'bx;
                end
                if (stcp_v[d]) stcp_run[d]++;
                else if (prev_stcp[d]) begin stcp_len[d] = stcp_run[d]; stcp_run[d] = 0; end
                if (shcp_v[d] && stcp_v[d]) overlap[d]++;
                if (fd_v[d]) begin
                    if (fd_cyc[d] >= 0) fd_gap[d] = cyc - fd_cyc[d];
                    fd_cyc[d] = cyc;
                    fd_cnt[d]++;
                end
                if (!oe_v[d] && first_oe_low[d] < 0) first_oe_low[d] = cyc;
                if (oe_v[d] && first_oe_low[d] >= 0) oe_relapse[d]++;
                prev_shcp[d] = shcp_v[d];
                prev_stcp[d] = stcp_v[d];
                prev_ds[d]   = ds_v[d];
            end
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after posedge; pins are read just after negedge, once the model has sampled them.
    task automatic tick(input bit rnd);
        @(posedge sys_clk);
        #1;
        if (rnd && $urandom_range(7) == 0) {sel, seg} = 14'($urandom);
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_fd(input int target, input int bound, input bit rnd);
        int n = 0;
        while (fd_cnt[0] < target && n < bound) begin
            tick(rnd);
            n++;
        end
        check("frame_done_timeout", 32'(fd_cnt[0] >= target), 32'd1);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        sel = 6'b000001;
        seg = 8'hC0;
        repeat (5) @(negedge sys_clk);
        #1;
        check("reset_pins_div4", {ds_v[0], shcp_v[0], stcp_v[0], oe_v[0], fd_v[0]}, 5'b00010);
        check("reset_pins_div8", {ds_v[1], shcp_v[1], stcp_v[1], oe_v[1], fd_v[1]}, 5'b00010);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        wait_fd(1, 200, 1'b0);
        check("first_done_cycle", fd_cyc[0], 60);
        check("oe_high_at_done", {fd_v[0], oe_v[0]}, 2'b11);
        tick(1'b0);
        check("oe_low_after_done", oe_v[0], 1'b0);
        check("oe_low_cycle", first_oe_low[0], 61);
        check("c0_ds_bits", latched[0], 14'b00000011000001);
        check("c0_rises", rises_at_latch[0], 14);
        check("stcp_len_div4", stcp_len[0], 4);
        check("shcp_high_div4", hi_len[0], 2);
        check("shcp_period_div4", period[0], 4);

        while (cyc - 1 < 82) tick(1'b0);
        seg = 8'hF9;
        wait_fd(2, 100, 1'b0);
        check("inflight_keeps_c0", latched[0], 14'b00000011000001);
        check("frame_gap_div4", fd_gap[0], 61);
        wait_fd(3, 100, 1'b0);
        check("next_frame_f9", latched[0], 14'b10011111000001);

        check("div8_done_count", fd_cnt[1], 1);
        check("div8_done_cycle", fd_cyc[1], 120);
        check("div8_oe_low_cycle", first_oe_low[1], 121);
        check("div8_c0_bits", latched[1], 14'b00000011000001);
        check("div8_rises", rises_at_latch[1], 14);
        check("div8_stcp_len", stcp_len[1], 8);
        check("div8_shcp_high", hi_len[1], 4);
        check("div8_shcp_period", period[1], 8);

        while (cyc - 1 < 214) tick(1'b0);
        check("bit7_mid_high", {ds_v[0], shcp_v[0]}, 2'b11);
        sys_rst_n = 1'b0;
        #1;
        check("midframe_reset_div4", {ds_v[0], shcp_v[0], stcp_v[0], oe_v[0], fd_v[0]}, 5'b00010);
        check("midframe_reset_div8", {ds_v[1], shcp_v[1], stcp_v[1], oe_v[1], fd_v[1]}, 5'b00010);
        {sel, seg} = 14'($urandom);
        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        wait_fd(1, 200, 1'b0);
        check("restart_done_cycle", fd_cyc[0], 60);
        check("restart_rises", rises_at_latch[0], 14);
        check("restart_word", latched[0], exp_bits(sel, seg));

        for (int f = 2; f < 12; f++) begin
            wait_fd(f, 100, 1'b1);
            check("rand_word", latched[0], exp_latch[0]);
            check("rand_rises", rises_at_latch[0], 14);
            check("rand_gap", fd_gap[0], 61);
        end
        check("div8_rand_word", latched[1], exp_latch[1]);
        check("div8_frame_gap", fd_gap[1], 121);
        check("overlap_div4", overlap[0], 0);
        check("overlap_div8", overlap[1], 0);
        check("ds_setup_div4", setup_viol[0], 0);
        check("ds_setup_div8", setup_viol[1], 0);
        check("ds_while_shcp_high", ds_hi_change[0] + ds_hi_change[1], 0);
        check("oe_relapse", oe_relapse[0] + oe_relapse[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
